// File: rtl/otter_iobus_periph.sv
`default_nettype none
// ============================================================================
// Module      : otter_iobus_periph
// Description : IOBUS target for the OTTER MCU. Provides synchronized switch
//               inputs, an LED register and a compare timer with prescaler,
//               auto-reload and a level interrupt. Read data is registered,
//               so data for an address in cycle N appears in cycle N+1.
// Revision    : 1.0 - initial release
// ============================================================================
module otter_iobus_periph #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
    parameter int          SW_WIDTH  = 16,
    parameter int          LED_WIDTH = 16,
    parameter int          PRESCALE  = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          IOBUS_ADDR,
    input  logic [31:0]          IOBUS_OUT,
    input  logic                 IOBUS_WR,
    output logic [31:0]          IOBUS_IN,
    input  logic [SW_WIDTH-1:0]  SWITCHES,
    output logic [LED_WIDTH-1:0] LEDS,
    output logic                 INTR
);

    // Register word indices (byte offset >> 2)
    localparam logic [5:0]  c_OFF_SW    = 6'h00;  // 0x00
    localparam logic [5:0]  c_OFF_LED   = 6'h08;  // 0x20
    localparam logic [5:0]  c_OFF_TCTRL = 6'h10;  // 0x40
    localparam logic [5:0]  c_OFF_TCMP  = 6'h11;  // 0x44
    localparam logic [5:0]  c_OFF_TCNT  = 6'h12;  // 0x48
    localparam logic [5:0]  c_OFF_TSTAT = 6'h13;  // 0x4C
    localparam logic [15:0] c_PRESC_LAST = 16'(PRESCALE - 1);

    logic [SW_WIDTH-1:0]  r_sw_meta;
    logic [SW_WIDTH-1:0]  r_sw_sync;
    logic [LED_WIDTH-1:0] r_led;
    logic                 r_en;
    logic                 r_auto;
    logic                 r_ie;
    logic [31:0]          r_tcmp;
    logic [31:0]          r_tcnt;
    logic                 r_match;
    logic [15:0]          r_presc;
    logic [31:0]          r_rdata;

    logic                 w_hit;
    logic [5:0]           w_off;
    logic                 w_wr_led;
    logic                 w_wr_tctrl;
    logic                 w_wr_tcmp;
    logic                 w_wr_tcnt;
    logic                 w_wr_tstat;
    logic                 w_tick;
    logic                 w_match_now;
    logic [31:0]          w_rdata;
    logic [31:0]          w_sw_ext;
    logic [31:0]          w_led_ext;
    logic                 w_unused_addr;

    // Address decode: 256-byte window, word access only
    assign w_hit         = (IOBUS_ADDR[31:8] == BASE_ADDR[31:8]);
    assign w_off         = IOBUS_ADDR[7:2];
    assign w_unused_addr = &{1'b0, IOBUS_ADDR[1:0]};

    assign w_wr_led   = IOBUS_WR & w_hit & (w_off == c_OFF_LED);
    assign w_wr_tctrl = IOBUS_WR & w_hit & (w_off == c_OFF_TCTRL);
    assign w_wr_tcmp  = IOBUS_WR & w_hit & (w_off == c_OFF_TCMP);
    assign w_wr_tcnt  = IOBUS_WR & w_hit & (w_off == c_OFF_TCNT);
    assign w_wr_tstat = IOBUS_WR & w_hit & (w_off == c_OFF_TSTAT);

    // A tick fires on the last prescaler count while the timer is enabled
    assign w_tick      = r_en & (r_presc == c_PRESC_LAST);
    assign w_match_now = w_tick & (r_tcnt == r_tcmp);

    assign LEDS     = r_led;
    assign INTR     = r_match & r_ie;
    assign IOBUS_IN = r_rdata;

    // Zero-extend the narrow registers to bus width and select read data
    always_comb begin
        w_sw_ext                  = '0;
        w_sw_ext[SW_WIDTH-1:0]    = r_sw_sync;
        w_led_ext                 = '0;
        w_led_ext[LED_WIDTH-1:0]  = r_led;
        w_rdata                   = '0;
        if (w_hit) begin
            case (w_off)
                c_OFF_SW:    w_rdata = w_sw_ext;
                c_OFF_LED:   w_rdata = w_led_ext;
                c_OFF_TCTRL: w_rdata = {29'd0, r_ie, r_auto, r_en};
                c_OFF_TCMP:  w_rdata = r_tcmp;
                c_OFF_TCNT:  w_rdata = r_tcnt;
                c_OFF_TSTAT: w_rdata = {31'd0, r_match};
                default:     w_rdata = '0;
            endcase
        end
    end

    // Registered read data: value from before the edge, one-cycle latency
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_rdata <= '0;
        else        r_rdata <= w_rdata;
    end

    // Two-flop synchronizer for the asynchronous switches
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= SWITCHES;
            r_sw_sync <= r_sw_meta;
        end
    end

    // LED output register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)        r_led <= '0;
        else if (w_wr_led) r_led <= IOBUS_OUT[LED_WIDTH-1:0];
    end

    // Timer control; a CPU write wins over the one-shot clear of EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_en   <= 1'b0;
            r_auto <= 1'b0;
            r_ie   <= 1'b0;
        end else if (w_wr_tctrl) begin
            r_en   <= IOBUS_OUT[0];
            r_auto <= IOBUS_OUT[1];
            r_ie   <= IOBUS_OUT[2];
        end else if (w_match_now && !r_auto) begin
            r_en   <= 1'b0;
        end
    end

    // Compare value register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)         r_tcmp <= '0;
        else if (w_wr_tcmp) r_tcmp <= IOBUS_OUT;
    end

    // Prescaler: runs while enabled, restarted by a TCNT write
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)          r_presc <= '0;
        else if (w_wr_tcnt)  r_presc <= '0;
        else if (r_en)       r_presc <= (r_presc == c_PRESC_LAST) ? 16'd0 : r_presc + 16'd1;
    end

    // Counter: CPU write wins; on a tick match reloads/holds, else increments
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_tcnt <= '0;
        end else if (w_wr_tcnt) begin
            r_tcnt <= IOBUS_OUT;
        end else if (w_tick) begin
            if (w_match_now) r_tcnt <= r_auto ? 32'd0 : r_tcnt;
            else             r_tcnt <= r_tcnt + 32'd1;
        end
    end

    // Match flag: set beats write-one-to-clear on the same edge
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_match <= 1'b0;
        else        r_match <= w_match_now | (r_match & ~(w_wr_tstat & IOBUS_OUT[0]));
    end

endmodule
`default_nettype wire

// File: tb/tb_otter_iobus_periph.sv
`default_nettype none
// ============================================================================
// Module      : tb_otter_iobus_periph
// Description : Scoreboard bench for otter_iobus_periph. Two instances share
//               the bus: one with PRESCALE=1, one with PRESCALE=4. Reads push
//               expected data; a monitor pops and compares one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otter_iobus_periph;

    localparam logic [31:0] c_BASE  = 32'h1100_0000;
    localparam logic [31:0] c_IDLE  = 32'h1100_00FC;
    localparam logic [31:0] c_SW    = 32'h1100_0000;
    localparam logic [31:0] c_LED   = 32'h1100_0020;
    localparam logic [31:0] c_TCTRL = 32'h1100_0040;
    localparam logic [31:0] c_TCMP  = 32'h1100_0044;
    localparam logic [31:0] c_TCNT  = 32'h1100_0048;
    localparam logic [31:0] c_TSTAT = 32'h1100_004C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr_en;
    logic [15:0] sw;
    logic [31:0] iobus_in1, iobus_in4;
    logic [15:0] leds1, leds4;
    logic        intr1, intr4;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] q_exp[$];
    bit          q_sel[$];
    string       q_name[$];
    bit          rd_req = 1'b0;
    bit          pend   = 1'b0;

    always #5 clk = ~clk;

    otter_iobus_periph #(.BASE_ADDR(c_BASE), .SW_WIDTH(16), .LED_WIDTH(16), .PRESCALE(1)) u_dut1 (
        .CLK(clk), .RESET(rst_n), .IOBUS_ADDR(addr), .IOBUS_OUT(wdata), .IOBUS_WR(wr_en),
        .IOBUS_IN(iobus_in1), .SWITCHES(sw), .LEDS(leds1), .INTR(intr1)
    );

    otter_iobus_periph #(.BASE_ADDR(c_BASE), .SW_WIDTH(16), .LED_WIDTH(16), .PRESCALE(4)) u_dut4 (
        .CLK(clk), .RESET(rst_n), .IOBUS_ADDR(addr), .IOBUS_OUT(wdata), .IOBUS_WR(wr_en),
        .IOBUS_IN(iobus_in4), .SWITCHES(sw), .LEDS(leds4), .INTR(intr4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a read issued before edge N presents data after edge N
    always @(posedge clk) pend <= rd_req;

    always @(negedge clk) begin
        if (pend) begin
            if (q_exp.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard_underflow: got read data with no expected entry");
            end else begin
                logic [31:0] e;
                bit          s;
                string       nm;
                e  = q_exp.pop_front();
                s  = q_sel.pop_front();
                nm = q_name.pop_front();
                chk(nm, s ? iobus_in4 : iobus_in1, e);
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        wdata = '0;
        addr  = c_IDLE;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input bit sel, input string name);
        addr   = a;
        rd_req = 1'b1;
        q_exp.push_back(e);
        q_sel.push_back(sel);
        q_name.push_back(name);
        @(negedge clk);
        rd_req = 1'b0;
        addr   = c_IDLE;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        addr  = c_IDLE;
        wdata = '0;
        wr_en = 1'b0;
        sw    = '0;
        #1 rst_n = 1'b0;
        idle(3);
        chk("leds_reset", {16'd0, leds1}, 32'd0);
        chk("intr_reset", {31'd0, intr1}, 32'd0);
        rst_n = 1'b1;
        rd(c_LED,   32'd0, 1'b0, "led_reset");
        rd(c_TCTRL, 32'd0, 1'b0, "tctrl_reset");
        rd(c_TCMP,  32'd0, 1'b0, "tcmp_reset");
        rd(c_TSTAT, 32'd0, 1'b0, "tstat_reset");

        // Asynchronous reset in the middle of a count
        wr(c_LED, 32'h0000_005A);
        wr(c_TCNT, 32'h0000_0010);
        wr(c_TCTRL, 32'h0000_0001);
        addr = c_LED;
        @(negedge clk);
        chk("iobus_in_before_reset", iobus_in1, 32'h0000_005A);
        #2 rst_n = 1'b0;
        #1;
        chk("iobus_in_async_reset", iobus_in1, 32'd0);
        chk("leds_async_reset", {16'd0, leds1}, 32'd0);
        chk("intr_async_reset", {31'd0, intr1}, 32'd0);
        @(negedge clk);
        addr  = c_IDLE;
        rst_n = 1'b1;
        wr(c_LED, 32'h0000_A5A5);
        chk("leds_first_write", {16'd0, leds1}, 32'h0000_A5A5);
        rd(c_TCNT, 32'd0, 1'b0, "tcnt_after_reset");
        rd(c_LED, 32'h0000_A5A5, 1'b0, "led_readback");

        // Switch synchronizer latency
        sw = 16'h1234;
        rd(c_SW, 32'd0,         1'b0, "sw_edge1");
        rd(c_SW, 32'd0,         1'b0, "sw_edge2");
        rd(c_SW, 32'h0000_1234, 1'b0, "sw_edge3");
        rd(c_SW, 32'h0000_1234, 1'b0, "sw_edge4");

        // One-shot timer, PRESCALE=1
        wr(c_TCMP, 32'd5);
        wr(c_TCNT, 32'd0);
        wr(c_TCTRL, 32'h0000_0005);
        for (int i = 0; i < 6; i++) rd(c_TCNT, 32'(i), 1'b0, "oneshot_tcnt");
        rd(c_TSTAT, 32'd1, 1'b0, "oneshot_match");
        rd(c_TCTRL, 32'h0000_0004, 1'b0, "oneshot_en_cleared");
        rd(c_TCNT, 32'd5, 1'b0, "oneshot_tcnt_hold");
        chk("oneshot_intr_set", {31'd0, intr1}, 32'd1);
        wr(c_TSTAT, 32'd1);
        chk("oneshot_intr_cleared", {31'd0, intr1}, 32'd0);

        // Auto-reload with PRESCALE=4
        wr(c_TCTRL, 32'd0);
        wr(c_TSTAT, 32'd1);
        wr(c_TCMP, 32'd2);
        wr(c_TCNT, 32'd0);
        wr(c_TCTRL, 32'h0000_0003);
        rd(c_TCNT, 32'd0, 1'b1, "auto_tcnt_e1");
        idle(3);
        rd(c_TCNT, 32'd1, 1'b1, "auto_tcnt_e5");
        idle(3);
        rd(c_TCNT, 32'd2, 1'b1, "auto_tcnt_e9");
        idle(1);
        rd(c_TSTAT, 32'd0, 1'b1, "auto_no_match_e11");
        rd(c_TSTAT, 32'd0, 1'b1, "auto_no_match_e12");
        rd(c_TSTAT, 32'd1, 1'b1, "auto_match_e13");
        rd(c_TCNT, 32'd0, 1'b1, "auto_reload");
        chk("auto_intr_ie_off", {31'd0, intr4}, 32'd0);
        idle(1);
        wr(c_TSTAT, 32'd1);
        rd(c_TSTAT, 32'd0, 1'b1, "auto_w1c");
        idle(6);
        wr(c_TSTAT, 32'd1);
        rd(c_TSTAT, 32'd1, 1'b1, "auto_set_beats_clear");
        rd(c_TCNT, 32'd0, 1'b1, "auto_second_reload");

        // CPU write to TCNT wins over a tick on the same edge
        wr(c_TCNT, 32'h0000_0100);
        rd(c_TCNT, 32'h0000_0100, 1'b0, "tcnt_write_priority");

        // CPU write to TCTRL wins over the one-shot clear of EN
        wr(c_TCTRL, 32'd0);
        wr(c_TSTAT, 32'd1);
        wr(c_TCMP, 32'd2);
        wr(c_TCNT, 32'd0);
        wr(c_TCTRL, 32'h0000_0001);
        idle(2);
        wr(c_TCTRL, 32'h0000_0001);
        rd(c_TCTRL, 32'h0000_0001, 1'b0, "tctrl_write_priority");

        // Decode
        wr(c_LED, 32'hFFFF_1234);
        chk("leds_low_bits", {16'd0, leds1}, 32'h0000_1234);
        rd(c_LED, 32'h0000_1234, 1'b0, "led_upper_zero");
        wr(32'h1200_0020, 32'h0000_BEEF);
        chk("leds_miss_write", {16'd0, leds1}, 32'h0000_1234);
        rd(32'h1200_0020, 32'd0, 1'b0, "read_no_hit");
        rd(c_BASE + 32'h60, 32'd0, 1'b0, "read_unmapped");

        // Counter wrap without match, then match and reload
        wr(c_TCTRL, 32'd0);
        wr(c_TSTAT, 32'd1);
        wr(c_TCMP, 32'd1);
        wr(c_TCNT, 32'hFFFF_FFFF);
        wr(c_TCTRL, 32'h0000_0003);
        rd(c_TCNT,  32'hFFFF_FFFF, 1'b0, "wrap_tcnt_max");
        rd(c_TSTAT, 32'd0,         1'b0, "wrap_no_match");
        rd(c_TCNT,  32'd1,         1'b0, "wrap_tcnt_1");
        rd(c_TCNT,  32'd0,         1'b0, "wrap_reload");
        rd(c_TSTAT, 32'd1,         1'b0, "wrap_match");

        for (int i = 0; i < 10 && q_exp.size() != 0; i++) @(negedge clk);
        if (q_exp.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
